pulse_gen_multi: RTL and testbench
==================================

Name: pulse_gen_multi

Overview:
- Multi-channel, parametrised change-to-pulse generator; the generalised successor of the single-channel observe/pulse block.
- Each channel watches a W-bit observed value and qualifies a change by requiring STABLE consecutive equal samples (glitch rejection).
- On each accepted change it emits a PULSE_LEN-cycle pulse, with either a retriggerable or a non-retriggerable pulse timer.
- Used by the pipeline CPU / LCD debug path to turn a selector or switch value change into step or refresh strobes.

Parameters:
- CH, 4, number of independent channels.
- W, 5, bits per observed value.
- STABLE, 3, consecutive equal samples needed to accept a change; must be >= 1.
- PULSE_LEN, 2, pulse width in clk cycles; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- observ  in  CH*W  observed values; channel i = bits [i*W +: W]; sampled directly each edge, no input synchroniser.
- retrig  in  1  0 = non-retriggerable, 1 = retriggerable; global, sampled each edge.
- ovr_clr  in  1  synchronous clear of all overrun flags.
- pulse  out  CH  per-channel pulse.
- value_o  out  CH*W  last accepted value per channel.
- busy  out  CH  channel is qualifying a candidate value.
- overrun  out  CH  sticky flag: a change was accepted while the pulse was active and retrig=0.

Behaviour:
- Reset, at the edge where rst=1: pulse=0, value_o=0, busy=0, overrun=0, qualifier state IDLE, timer=0.
- Reset overrides everything, including a channel mid-qualification or mid-pulse; outputs are 0 after that edge.
- The accepted value resets to 0, so a nonzero observ held after reset is detected as a change.

Qualifier, per channel (registers: acc, cand, cnt):
- IDLE, observ==acc: stay in IDLE.
- IDLE, observ!=acc, STABLE==1: accept immediately.
- IDLE, observ!=acc, STABLE>1: cand=observ, cnt=1, go to QUAL, busy=1.
- QUAL, observ==cand: cnt++; when cnt reaches STABLE, accept and return to IDLE.
- QUAL, observ==acc: glitch; return to IDLE, no pulse.
- QUAL, any other value: cand=observ, cnt=1; qualification restarts.
- Accept: acc=cand (or observ when STABLE==1); value_o updates at the same edge; a 1-cycle internal strobe acc_stb goes to the timer.
- Latency: if a new value is first sampled at edge t and held, value_o and pulse rise after edge t+STABLE-1.

Timer, per channel (counter of width clog2(PULSE_LEN+1)):
- pulse = (timer != 0), registered.
- acc_stb while timer==0: load PULSE_LEN.
- acc_stb while timer!=0, retrig=1: reload PULSE_LEN, so the pulse extends with no low gap.
- acc_stb while timer!=0, retrig=0: timer continues unchanged; set overrun.
- Otherwise the timer decrements to 0 and saturates there.
- If ovr_clr and a new overrun event occur at the same edge, the set wins.
- The qualifier runs during an active pulse; value_o always reflects the latest accepted value.

General:
- Channels are fully independent; simultaneous events on different channels must not interact.
- Counters never wrap: cnt saturates at STABLE and the timer saturates at 0.

Decomposition:
- Shared package: state enum {IDLE, QUAL}; localparams CNT_W = clog2(STABLE+1) and TMR_W = clog2(PULSE_LEN+1).
- One sub-module, pulse_chan: one channel containing qualifier and timer.
- Top level: a generate loop of CH pulse_chan instances plus port slicing.

Test Plan:
- Reset with observ=0 for 5 cycles: pulse, busy, overrun and value_o all 0. Assert rst mid-pulse: pulse=0 after that edge.
- Defaults; ch0 observ 0->1, first sampled at edge 10 and held: busy=1 after edges 10-11; value_o[0]=1 and pulse[0]=1 after edges 12 and 13; pulse[0]=0 after edge 14; other channels stay 0.
- Glitch rejection: ch1 0->7 for 2 cycles, then back to 0: pulse[1] never rises, value_o[1] stays 0, busy[1] returns to 0.
- Bounce: ch2 1 (accepted), then 7 for 1 cycle, then 11 held: exactly one pulse, value_o[2]=11, rising 3 edges after 11 is first sampled.
- STABLE=1, PULSE_LEN=4; ch0 changes 1->2->3 at edges 0 and 2, retrig=1: pulse high continuously for 6 cycles, overrun=0.
  Same stimulus with retrig=0: pulse high for 4 cycles, value_o=3, overrun[0]=1 until ovr_clr.
- All 4 channels change in the same cycle: 4 simultaneous identical pulses with independent value_o fields; rst asserted during QUAL: busy=0 and no pulse afterwards.

Source files
------------

// File: rtl/pulse_gen_multi_pkg.sv
// Shared types and sizing helpers for the multi-channel change-to-pulse generator.
package pulse_gen_multi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      QUAL = 1'b1
   } qual_state_t;

   localparam int STABLE_DEF    = 3;
   localparam int PULSE_LEN_DEF = 2;

   // Bits needed to hold 0..maxval inclusive; never less than one bit.
   function automatic int cnt_bits(input int maxval);
      return (maxval < 1) ? 1 : $clog2(maxval + 1);
   endfunction

   localparam int CNT_W = cnt_bits(STABLE_DEF);
   localparam int TMR_W = cnt_bits(PULSE_LEN_DEF);

endpackage

// File: rtl/pulse_gen_multi_if.sv
// Observed-value inputs and per-channel status outputs of pulse_gen_multi.
interface pulse_gen_multi_if #(
   parameter int CH = 4,
   parameter int W  = 5
);

   logic [CH*W-1:0] observ;
   logic            retrig;
   logic            ovr_clr;
   logic [CH-1:0]   pulse;
   logic [CH*W-1:0] value_o;
   logic [CH-1:0]   busy;
   logic [CH-1:0]   overrun;

   modport master (
      output observ, retrig, ovr_clr,
      input  pulse, value_o, busy, overrun
   );

   modport slave (
      input  observ, retrig, ovr_clr,
      output pulse, value_o, busy, overrun
   );

endinterface

// File: rtl/pulse_gen_multi_chan.sv
// One channel: glitch-rejecting change qualifier feeding a down-counting pulse timer.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | observed value matches the accepted value, nothing pending
//   QUAL  | a different candidate value is being counted for stability
module pulse_chan
   import pulse_gen_multi_pkg::*;
#(
   parameter int W         = 5,
   parameter int STABLE    = STABLE_DEF,
   parameter int PULSE_LEN = PULSE_LEN_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] observ,
   input  logic         retrig,
   input  logic         ovr_clr,
   output logic         pulse,
   output logic [W-1:0] value_o,
   output logic         busy,
   output logic         overrun
);

   localparam int CW = cnt_bits(STABLE);
   localparam int TW = cnt_bits(PULSE_LEN);

   qual_state_t   state, state_n;
   logic [W-1:0]  acc, acc_n;
   logic [W-1:0]  cand, cand_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [TW-1:0] tmr, tmr_n;
   logic          ovr_n;
   logic          acc_stb;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         cand    <= '0;
         cnt     <= '0;
         tmr     <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         cand    <= cand_n;
         cnt     <= cnt_n;
         tmr     <= tmr_n;
         overrun <= ovr_n;
      end
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      cand_n  = cand;
      cnt_n   = cnt;
      acc_stb = 1'b0;
      cnt_inc = (cnt == CW'(STABLE)) ? cnt : cnt + CW'(1);

      case (state)
         IDLE: begin
            if (observ != acc) begin
               if (STABLE == 1) begin
                  acc_n   = observ;
                  acc_stb = 1'b1;
               end else begin
                  cand_n  = observ;
                  cnt_n   = CW'(1);
                  state_n = QUAL;
               end
            end
         end
         QUAL: begin
            if (observ == cand) begin
               cnt_n = cnt_inc;
               if (cnt_inc == CW'(STABLE)) begin
                  acc_n   = cand;
                  acc_stb = 1'b1;
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end else if (observ == acc) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cand_n = observ;
               cnt_n  = CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Same-edge overrun set beats a pending clear.
   always_comb begin
      tmr_n = tmr;
      ovr_n = overrun;
      if (ovr_clr) ovr_n = 1'b0;
      if (acc_stb) begin
         if (tmr == '0 || retrig) begin
            tmr_n = TW'(PULSE_LEN);
         end else begin
            tmr_n = tmr - TW'(1);
            ovr_n = 1'b1;
         end
      end else if (tmr != '0) begin
         tmr_n = tmr - TW'(1);
      end
   end

   assign pulse   = (tmr != '0);
   assign value_o = acc;
   assign busy    = (state == QUAL);

endmodule

// File: rtl/pulse_gen_multi.sv
// Top level: CH independent pulse_chan instances sliced onto the shared bus.
module pulse_gen_multi
   import pulse_gen_multi_pkg::*;
#(
   parameter int CH        = 4,
   parameter int W         = 5,
   parameter int STABLE    = STABLE_DEF,
   parameter int PULSE_LEN = PULSE_LEN_DEF
) (
   input logic             clk,
   input logic             rst,
   pulse_gen_multi_if.slave bus
);

   for (genvar i = 0; i < CH; i++) begin : g_chan
      pulse_chan #(
         .W         (W),
         .STABLE    (STABLE),
         .PULSE_LEN (PULSE_LEN)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .observ  (bus.observ[i*W +: W]),
         .retrig  (bus.retrig),
         .ovr_clr (bus.ovr_clr),
         .pulse   (bus.pulse[i]),
         .value_o (bus.value_o[i*W +: W]),
         .busy    (bus.busy[i]),
         .overrun (bus.overrun[i])
      );
   end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: default build (dut_a) plus a STABLE=1, PULSE_LEN=4 build (dut_b).
module tb_pulse_gen_multi;

   localparam int CH = 4;
   localparam int W  = 5;

   typedef struct {
      int           ch;
      logic [W-1:0] val;
      int           e_at;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   bad    = 0;
   int   edge_n = 0;
   exp_t sbq[$];
   logic [CH-1:0] prev_a = '0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_n++;

   pulse_gen_multi_if #(.CH(CH), .W(W)) bus_a ();
   pulse_gen_multi_if #(.CH(CH), .W(W)) bus_b ();

   pulse_gen_multi #(.CH(CH), .W(W), .STABLE(3), .PULSE_LEN(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   pulse_gen_multi #(.CH(CH), .W(W), .STABLE(1), .PULSE_LEN(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Every rising pulse on dut_a must match the oldest queued acceptance for that channel.
   always @(negedge clk) begin
      int idx;
      if (rst) begin
         prev_a = '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (bus_a.pulse[i] && !prev_a[i]) begin
               idx = -1;
               for (int k = 0; k < sbq.size(); k++)
                  if (idx < 0 && sbq[k].ch == i) idx = k;
               total++;
               if (idx < 0) begin
                  bad++;
                  $display("FAIL sb_unexpected ch%0d: pulse rose at edge %0d, none required", i, edge_n);
               end else begin
                  if (bus_a.value_o[i*W +: W] !== sbq[idx].val || edge_n != sbq[idx].e_at) begin
                     bad++;
                     $display("FAIL sb_pulse ch%0d: value=%0d edge=%0d, required value=%0d edge=%0d",
                              i, bus_a.value_o[i*W +: W], edge_n, sbq[idx].val, sbq[idx].e_at);
                  end
                  sbq.delete(idx);
               end
            end
         end
         prev_a = bus_a.pulse;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      bus_a.observ = '0; bus_a.retrig = 1'b0; bus_a.ovr_clr = 1'b0;
      bus_b.observ = '0; bus_b.retrig = 1'b0; bus_b.ovr_clr = 1'b0;
      tick(5);
      total++;
      if (bus_a.pulse !== '0 || bus_a.busy !== '0) begin
         bad++; $display("FAIL reset_a_pulse_busy: pulse=%b busy=%b, required 0", bus_a.pulse, bus_a.busy);
      end
      total++;
      if (bus_a.overrun !== '0 || bus_a.value_o !== '0) begin
         bad++; $display("FAIL reset_a_ovr_val: overrun=%b value_o=%h, required 0", bus_a.overrun, bus_a.value_o);
      end
      total++;
      if ({bus_b.pulse, bus_b.busy, bus_b.overrun, bus_b.value_o} !== '0) begin
         bad++; $display("FAIL reset_b: pulse=%b busy=%b ovr=%b val=%h, required 0",
                         bus_b.pulse, bus_b.busy, bus_b.overrun, bus_b.value_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic         exp_busy, exp_pulse;
      logic [W-1:0] exp_val;
      int           e;
      bus_a.observ[4:0] = 5'd1;
      e = edge_n + 1;
      sbq.push_back('{0, 5'd1, e + 2});
      for (int k = 0; k < 5; k++) begin
         tick();
         exp_busy  = (k < 2);
         exp_pulse = (k == 2 || k == 3);
         exp_val   = (k >= 2) ? 5'd1 : 5'd0;
         total++;
         if (bus_a.busy[0] !== exp_busy || bus_a.pulse[0] !== exp_pulse || bus_a.value_o[4:0] !== exp_val) begin
            bad++;
            $display("FAIL basic_ch0 step%0d: busy=%b pulse=%b val=%0d, required busy=%b pulse=%b val=%0d",
                     k, bus_a.busy[0], bus_a.pulse[0], bus_a.value_o[4:0], exp_busy, exp_pulse, exp_val);
         end
         total++;
         if (bus_a.pulse[3:1] !== 3'b000 || bus_a.value_o[19:5] !== '0) begin
            bad++;
            $display("FAIL basic_others step%0d: pulse=%b val=%h, required 0", k, bus_a.pulse[3:1], bus_a.value_o[19:5]);
         end
      end
   endtask

   task automatic test_glitch();
      bus_a.observ[9:5] = 5'd7;
      tick(2);
      total++;
      if (bus_a.busy[1] !== 1'b1) begin
         bad++; $display("FAIL glitch_busy_high: busy1=%b, required 1", bus_a.busy[1]);
      end
      bus_a.observ[9:5] = 5'd0;
      tick();
      total++;
      if (bus_a.busy[1] !== 1'b0) begin
         bad++; $display("FAIL glitch_busy_low: busy1=%b, required 0", bus_a.busy[1]);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if (bus_a.pulse[1] !== 1'b0 || bus_a.value_o[9:5] !== 5'd0) begin
            bad++; $display("FAIL glitch_quiet step%0d: pulse1=%b val1=%0d, required 0 0", k, bus_a.pulse[1], bus_a.value_o[9:5]);
         end
      end
   endtask

   task automatic test_bounce();
      int   rises;
      logic prev;
      bus_a.observ[14:10] = 5'd1;
      sbq.push_back('{2, 5'd1, edge_n + 3});
      tick(6);
      bus_a.observ[14:10] = 5'd7;
      tick();
      bus_a.observ[14:10] = 5'd11;
      sbq.push_back('{2, 5'd11, edge_n + 3});
      rises = 0;
      prev  = bus_a.pulse[2];
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus_a.pulse[2] && !prev) rises++;
         prev = bus_a.pulse[2];
      end
      total++;
      if (rises != 1) begin
         bad++; $display("FAIL bounce_pulses: rises=%0d, required 1", rises);
      end
      total++;
      if (bus_a.value_o[14:10] !== 5'd11) begin
         bad++; $display("FAIL bounce_value: val2=%0d, required 11", bus_a.value_o[14:10]);
      end
      total++;
      if (sbq.size() != 0) begin
         bad++; $display("FAIL bounce_sb_drain: %0d acceptances pending, required 0", sbq.size());
      end
   endtask

   task automatic test_all_channels();
      logic [CH*W-1:0] nv;
      logic [CH-1:0]   exp_p;
      int              e;
      nv = {5'd30, 5'd21, 5'd12, 5'd3};
      bus_a.observ = nv;
      e = edge_n + 1;
      for (int i = 0; i < CH; i++) sbq.push_back('{i, nv[i*W +: W], e + 2});
      for (int k = 0; k < 5; k++) begin
         tick();
         exp_p = (k == 2 || k == 3) ? 4'hF : 4'h0;
         total++;
         if (bus_a.pulse !== exp_p) begin
            bad++; $display("FAIL all_pulse step%0d: pulse=%b, required %b", k, bus_a.pulse, exp_p);
         end
         if (k == 0) begin
            total++;
            if (bus_a.busy !== 4'hF) begin
               bad++; $display("FAIL all_busy: busy=%b, required 1111", bus_a.busy);
            end
         end
         if (k == 2) begin
            total++;
            if (bus_a.value_o !== nv) begin
               bad++; $display("FAIL all_value: value_o=%h, required %h", bus_a.value_o, nv);
            end
         end
      end
   endtask

   task automatic run_b_pair(output int hi, output int rises);
      logic prev;
      hi = 0; rises = 0; prev = 1'b0;
      bus_b.observ[4:0] = 5'd2;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 1) bus_b.observ[4:0] = 5'd3;
         if (bus_b.pulse[0]) hi++;
         if (bus_b.pulse[0] && !prev) rises++;
         prev = bus_b.pulse[0];
      end
   endtask

   task automatic test_retrig();
      int hi, rises;
      bus_b.retrig = 1'b1;
      bus_b.observ[4:0] = 5'd1;
      tick(6);
      run_b_pair(hi, rises);
      total++;
      if (hi != 6 || rises != 1) begin
         bad++; $display("FAIL retrig_width: high=%0d rises=%0d, required 6 1", hi, rises);
      end
      total++;
      if (bus_b.overrun[0] !== 1'b0 || bus_b.value_o[4:0] !== 5'd3) begin
         bad++; $display("FAIL retrig_state: ovr=%b val=%0d, required 0 3", bus_b.overrun[0], bus_b.value_o[4:0]);
      end
   endtask

   task automatic test_noretrig();
      int hi, rises;
      bus_b.retrig = 1'b0;
      bus_b.observ[4:0] = 5'd1;
      tick(6);
      run_b_pair(hi, rises);
      total++;
      if (hi != 4 || rises != 1) begin
         bad++; $display("FAIL noretrig_width: high=%0d rises=%0d, required 4 1", hi, rises);
      end
      total++;
      if (bus_b.overrun[0] !== 1'b1 || bus_b.value_o[4:0] !== 5'd3) begin
         bad++; $display("FAIL noretrig_state: ovr=%b val=%0d, required 1 3", bus_b.overrun[0], bus_b.value_o[4:0]);
      end
      total++;
      if (bus_b.overrun[3:1] !== 3'b000) begin
         bad++; $display("FAIL noretrig_others: ovr=%b, required 000", bus_b.overrun[3:1]);
      end
      bus_b.ovr_clr = 1'b1;
      tick();
      bus_b.ovr_clr = 1'b0;
      total++;
      if (bus_b.overrun[0] !== 1'b0) begin
         bad++; $display("FAIL ovr_clear: ovr=%b, required 0", bus_b.overrun[0]);
      end
      bus_b.observ[4:0] = 5'd5;
      tick();
      bus_b.observ[4:0] = 5'd6;
      bus_b.ovr_clr = 1'b1;
      tick();
      bus_b.ovr_clr = 1'b0;
      total++;
      if (bus_b.overrun[0] !== 1'b1) begin
         bad++; $display("FAIL ovr_set_wins: ovr=%b, required 1", bus_b.overrun[0]);
      end
      tick(5);
   endtask

   task automatic test_reset_mid();
      bus_a.observ[4:0] = 5'd4;
      sbq.push_back('{0, 5'd4, edge_n + 3});
      tick(3);
      total++;
      if (bus_a.pulse[0] !== 1'b1) begin
         bad++; $display("FAIL midpulse_pre: pulse0=%b, required 1", bus_a.pulse[0]);
      end
      rst = 1'b1;
      bus_a.observ = '0;
      sbq.delete();
      tick();
      total++;
      if (bus_a.pulse !== '0 || bus_a.value_o !== '0) begin
         bad++; $display("FAIL midpulse_rst: pulse=%b val=%h, required 0", bus_a.pulse, bus_a.value_o);
      end
      rst = 1'b0;
      tick();
      bus_a.observ[19:15] = 5'd5;
      tick();
      total++;
      if (bus_a.busy[3] !== 1'b1) begin
         bad++; $display("FAIL midqual_pre: busy3=%b, required 1", bus_a.busy[3]);
      end
      rst = 1'b1;
      bus_a.observ = '0;
      tick();
      rst = 1'b0;
      total++;
      if (bus_a.busy !== '0) begin
         bad++; $display("FAIL midqual_rst: busy=%b, required 0", bus_a.busy);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (bus_a.pulse !== '0 || bus_a.busy !== '0) begin
            bad++; $display("FAIL midqual_after step%0d: pulse=%b busy=%b, required 0", k, bus_a.pulse, bus_a.busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_bounce();
      test_all_channels();
      test_retrig();
      test_noretrig();
      test_reset_mid();
      total++;
      if (sbq.size() != 0) begin
         bad++; $display("FAIL sb_final: %0d acceptances pending, required 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
